// File: rtl/uart_rx.sv
// 8N1 UART receiver with configurable oversampling, mid-bit sampling and
// frame-error reporting. Consumes a shared b_tick strobe at OVERSAMPLE x baud.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_d;
  logic            done_d, ferr_d;
  logic            rx_meta, rx_s;

  // Synchronizer flops reset high so a reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two flops as a true shift chain.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = rx_data;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (b_tick) begin
          if (tick_q == TICK_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (b_tick) begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s, shift_q[7:1]};
            tick_d  = '0;
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (b_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = IDLE;
            // Returning to IDLE here lets a held-low line re-arm as a new start.
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_done   <= done_d;
      frame_err <= ferr_d;
    end
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of 8N1 frames plus hand-written false-start,
// break and mid-frame reset sequences. b_tick every 4 clk, OVERSAMPLE = 16.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       b_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int n_vec  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err  = 0;
  logic overlap_seen = 1'b0;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .b_tick    (b_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    b_tick = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      b_tick = (ph == 0);
    end
  end

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_done)   n_done <= n_done + 1;
    if (frame_err) n_err  <= n_err + 1;
    if (rx_done && frame_err) overlap_seen <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int clks);
    rx = 1'b1;
    repeat (clks) @(negedge clk);
  endtask

  // Drives one frame starting at a falling clk edge; returns rx_busy seen mid data bit 4.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int bit_clks,
                             input int stop_clks, output logic busy_mid);
    busy_mid = 1'b0;
    rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == 4) begin
        repeat (bit_clks / 2) @(negedge clk);
        busy_mid = rx_busy;
        repeat (bit_clks - bit_clks / 2) @(negedge clk);
      end else begin
        repeat (bit_clks) @(negedge clk);
      end
    end
    rx = stop;
    repeat (stop_clks) @(negedge clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bit_clks;
    int         stop_clks;
    int         gap;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int d0, e0;
    logic bm;
    logic [7:0] held;

    vecs[0] = '{8'hA5, 1'b1, 64, 64,  64, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 64, 64,  64, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 64, 64,  64, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 64, 48, 128, 0, 1, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 62, 62,  64, 1, 0, 8'h81};
    vecs[5] = '{8'h5A, 1'b1, 64, 64,  64, 1, 0, 8'h5A};
    vecs[6] = '{8'h81, 1'b1, 66, 66,  64, 1, 0, 8'h81};

    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rx_data",   32'(rx_data),   32'h00);
    check("reset rx_done",   32'(rx_done),   32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset rx_busy",   32'(rx_busy),   32'h0);
    reset = 1'b1;
    idle(40);

    for (int v = 0; v < 7; v++) begin
      d0 = n_done;
      e0 = n_err;
      drive_frame(vecs[v].data, vecs[v].stop, vecs[v].bit_clks, vecs[v].stop_clks, bm);
      idle(vecs[v].gap);
      check($sformatf("v%0d busy mid-frame", v), 32'(bm), 32'h1);
      check($sformatf("v%0d busy after", v), 32'(rx_busy), 32'h0);
      check($sformatf("v%0d rx_done pulses", v), 32'(n_done - d0), 32'(vecs[v].exp_done));
      check($sformatf("v%0d frame_err pulses", v), 32'(n_err - e0), 32'(vecs[v].exp_err));
      check($sformatf("v%0d rx_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
    end

    // False start: low for 3 b_tick periods, then high.
    d0 = n_done; e0 = n_err; held = rx_data;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("false start busy", 32'(rx_busy), 32'h1);
    idle(60);
    check("false start busy falls", 32'(rx_busy), 32'h0);
    check("false start rx_done", 32'(n_done - d0), 32'h0);
    check("false start frame_err", 32'(n_err - e0), 32'h0);
    check("false start rx_data", 32'(rx_data), 32'(held));

    // Break: line held low long enough for exactly two stop-bit samples.
    d0 = n_done; e0 = n_err;
    rx = 1'b0;
    repeat (1240) @(negedge clk);
    idle(800);
    check("break frame_err", 32'(n_err - e0), 32'h2);
    check("break rx_done", 32'(n_done - d0), 32'h0);
    check("break rx_data", 32'(rx_data), 32'(held));

    // Reset during data bit 4, then a clean 8'h5A frame.
    d0 = n_done; e0 = n_err;
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (64) @(negedge clk);
    end
    rx = 1'b0;
    repeat (32) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid-frame reset rx_data", 32'(rx_data), 32'h00);
    check("mid-frame reset rx_busy", 32'(rx_busy), 32'h0);
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    idle(800);
    check("aborted frame rx_done", 32'(n_done - d0), 32'h0);
    check("aborted frame frame_err", 32'(n_err - e0), 32'h0);
    drive_frame(8'h5A, 1'b1, 64, 64, bm);
    idle(64);
    check("post-reset rx_done", 32'(n_done - d0), 32'h1);
    check("post-reset rx_data", 32'(rx_data), 32'h5A);
    check("post-reset frame_err", 32'(n_err - e0), 32'h0);

    check("rx_done/frame_err overlap", 32'(overlap_seen), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: OVERSAMPLE, default 16, the number of b_tick pulses per bit period (even, >= 8).
REQ-002 SHALL have port: clk  input  1  the single system clock; all state changes on the rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (reset = 0 resets the block).
REQ-004 SHALL have port: b_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate, from the shared baud tick generator.
REQ-005 SHALL have port: rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-006 SHALL have port: rx_data  output  8  last correctly framed byte; holds until the next good frame.
REQ-007 SHALL have port: rx_done  output  1  one-clk pulse; rx_data is valid from this cycle onward.
REQ-008 SHALL have port: rx_busy  output  1  high while a frame is being received (any state other than IDLE).
REQ-009 SHALL have port: frame_err  output  1  one-clk pulse when the stop bit is sampled low.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer, with the first flop reset to 1; all later logic uses only the synchronized value rx_s.
REQ-011 SHALL implement the FSM states IDLE, START, DATA and STOP, with registered current/next state.
REQ-012 SHALL use a tick counter tick_cnt with range 0..OVERSAMPLE-1 that advances only on cycles where b_tick=1.
REQ-013 SHALL use a bit counter bit_cnt of 3 bits with range 0..7, and an 8-bit shift register.
REQ-014 In IDLE, SHALL go to START and clear tick_cnt on the first clk where rx_s=0; b_tick is not required for this transition.
REQ-015 In START, on a b_tick with tick_cnt = OVERSAMPLE/2-1 (mid start bit):
  - if rx_s=0: go to DATA, clear tick_cnt and bit_cnt;
  - if rx_s=1: treat as a false start and return to IDLE, with no rx_done and no frame_err.
REQ-016 In DATA, on a b_tick with tick_cnt = OVERSAMPLE-1:
  - sample rx_s and shift it into the MSB of the shift register (right shift), so the byte ends LSB-first correct;
  - clear tick_cnt;
  - if bit_cnt=7, go to STOP; otherwise increment bit_cnt.
REQ-017 In STOP, on a b_tick with tick_cnt = OVERSAMPLE-1:
  - if rx_s=1: load rx_data from the shift register, pulse rx_done, go to IDLE;
  - if rx_s=0: pulse frame_err, leave rx_data unchanged, go to IDLE.
REQ-018 SHALL register rx_done and frame_err so each is high for exactly one clk, in the cycle after the sampling b_tick; the two SHALL never be high together.
REQ-019 SHALL return to IDLE, after a frame error, on the same sampling edge, so a frame whose line is still low can be re-detected as a new start (break condition yields repeated frame_err).
REQ-020 SHALL ignore b_tick while in IDLE; in other states, clk cycles without b_tick SHALL change no counter.
REQ-021 SHALL drive rx_busy=1 in START, DATA and STOP, and rx_busy=0 in IDLE; rx_busy is registered state, not a decode of rx.
REQ-022 SHALL have a latency from the stop-bit mid-sample b_tick to rx_done=1 of exactly 1 clk.
REQ-023 rx_data SHALL NOT change on a false start, a frame error, or a partially received frame.

Reset
REQ-024 While reset=0, SHALL asynchronously force:
  - state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0;
  - rx_data=8'h00, rx_done=0, frame_err=0, rx_busy=0;
  - synchronizer flops=1.
REQ-025 SHALL, on reset asserted mid-frame, abort the frame with no rx_done or frame_err pulse; after release, the block SHALL wait in IDLE for a new falling edge.
REQ-026 SHALL begin normal operation on the first rising clk edge after reset returns to 1.

Verification
REQ-027 Send byte 8'hA5 (8N1, b_tick every 4 clk, OVERSAMPLE=16) -> rx_done one pulse, rx_data=8'hA5, frame_err stays 0, rx_busy high from start detect until the rx_done cycle.
REQ-028 Send 8'h00 then 8'hFF back-to-back with a 1-bit idle gap -> two rx_done pulses, rx_data=8'h00 then 8'hFF.
REQ-029 Pulse rx low for 3 b_tick periods, then high -> return to IDLE, rx_busy falls, no rx_done, no frame_err, rx_data unchanged.
REQ-030 Send 8'h3C with stop bit forced 0 -> frame_err one pulse, no rx_done, rx_data keeps its previous value.
REQ-031 Drive reset=0 during data bit 4 of a frame, release, then send 8'h5A -> outputs reset immediately, no pulse from the aborted frame, next rx_data=8'h5A.
REQ-032 Send 8'h81 with the bit period skewed by +/-3% -> rx_data=8'h81 and no frame_err.
